// File: rtl/timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : timing_gen
// Brief    : Two-phase (clk1/clk2) strobe generator sequencing an 8-state
//            one-hot machine cycle A1..X3, with stop/resume at X3.
// Revision : 1.0 - initial release
// ============================================================================
module timing_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic       sysclk,
    input  logic       poc,
    input  logic       run,
    output logic       clk1,
    output logic       clk2,
    output logic [7:0] state,
    output logic       sync
);

    localparam int unsigned    CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  c_DIV_LAST = CW'(DIV - 1);

    typedef enum logic [7:0] {
        S_A1 = 8'b0000_0001,
        S_A2 = 8'b0000_0010,
        S_A3 = 8'b0000_0100,
        S_M1 = 8'b0000_1000,
        S_M2 = 8'b0001_0000,
        S_X1 = 8'b0010_0000,
        S_X2 = 8'b0100_0000,
        S_X3 = 8'b1000_0000
    } state_t;

    logic [CW-1:0] r_div_cnt;
    logic          r_half;
    logic          r_clk1;
    logic          r_clk2;
    state_t        r_state;
    logic          w_tick;

    function automatic state_t next_state(input state_t s);
        case (s)
            S_A1:    next_state = S_A2;
            S_A2:    next_state = S_A3;
            S_A3:    next_state = S_M1;
            S_M1:    next_state = S_M2;
            S_M2:    next_state = S_X1;
            S_X1:    next_state = S_X2;
            S_X2:    next_state = S_X3;
            default: next_state = S_A1;
        endcase
    endfunction

    assign w_tick = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            r_div_cnt <= '0;
            r_half    <= 1'b0;
            r_clk1    <= 1'b0;
            r_clk2    <= 1'b0;
            r_state   <= S_X3;
        end else begin
            r_clk1 <= 1'b0;
            r_clk2 <= 1'b0;
            if (w_tick) begin
                r_div_cnt <= '0;
                if (!r_half) begin
                    // A stopped machine parks in X3 with half left at 0, so
                    // every later tick re-evaluates run as a clk1 tick.
                    if ((r_state != S_X3) || run) begin
                        r_clk1  <= 1'b1;
                        r_state <= next_state(r_state);
                        r_half  <= 1'b1;
                    end
                end else begin
                    r_clk2 <= 1'b1;
                    r_half <= 1'b0;
                end
            end else begin
                r_div_cnt <= r_div_cnt + CW'(1);
            end
        end
    end

    assign clk1  = r_clk1;
    assign clk2  = r_clk2;
    assign state = r_state;
    assign sync  = r_state[7];

endmodule
`default_nettype wire

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 Parameter: DIV, default 4, sysclk cycles per half-phase; legal range 2..255; values outside this range are illegal and need not be checked.
REQ-002 Port: sysclk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 Port: poc, input, 1, power-on clear; asynchronous, active-high reset.
REQ-004 Port: run, input, 1, level; 1 = keep sequencing, 0 = stop at X3.
REQ-005 Port: clk1, output, 1, registered one-sysclk strobe marking phase 1; used as step_a by downstream two-phase storage cells.
REQ-006 Port: clk2, output, 1, registered one-sysclk strobe marking phase 2; used as step_b by downstream two-phase storage cells.
REQ-007 Port: state, output, 8, one-hot machine state, bit0..bit7 = A1,A2,A3,M1,M2,X1,X2,X3.
REQ-008 Port: sync, output, 1, high exactly while state = X3.

Function
REQ-009 The prescaler div_cnt shall count 0..DIV-1 and wrap to 0; the edge on which it wraps is a "tick".
REQ-010 A half flag shall select which strobe a tick produces: half=0 gives a clk1 tick, half=1 gives a clk2 tick; half toggles on every tick that issues a strobe.
REQ-011 On a clk1 tick, clk1 shall be 1 for exactly the following sysclk cycle, and state shall advance one position on that same edge (X3 wraps to A1).
REQ-012 On a clk2 tick, clk2 shall be 1 for exactly the following sysclk cycle; state shall be unchanged.
REQ-013 On every non-tick edge, clk1 and clk2 shall be 0; clk1 and clk2 shall never be 1 together.
REQ-014 While sequencing, strobe spacing shall be: clk1 to clk2 = DIV cycles, clk2 to next clk1 = DIV cycles, one machine phase = 2*DIV cycles, one full 8-phase cycle = 16*DIV cycles.
REQ-015 state shall always be exactly one-hot, including immediately after reset.
REQ-016 sync shall be decoded from the state register with no added latency.
REQ-017 Stop: on a clk1 tick with state = X3 and run = 0, no clk1 shall be issued, state shall stay X3, half shall stay 0, and the prescaler shall keep wrapping.
REQ-018 Resume: run is re-evaluated at every subsequent tick; the first tick with run = 1 shall issue clk1 and enter A1, so resume latency is at most DIV cycles.
REQ-019 run shall be ignored in every state other than X3, and at every clk2 tick; a stop request mid-cycle completes the cycle through X3.
REQ-020 No strobes shall be generated while poc is high.

Reset
REQ-021 When poc is asserted, the block shall asynchronously force div_cnt=0, half=0, clk1=0, clk2=0, state=X3 (8'b1000_0000), and therefore sync=1.
REQ-022 Assertion of poc mid-phase shall abandon the phase immediately; no partial or late strobe shall appear after poc is released.
REQ-023 After poc is released, the first tick shall occur on the DIV-th rising edge and shall be a clk1 tick (subject to run) that enters A1.

Verification
REQ-024 DIV=4, run=1, poc released before edge 1 -> clk1 high after edges 4, 12, 20, ...; clk2 high after edges 8, 16, ...; state=A1 from edge 4 and A2 from edge 12; sync=1 until edge 4.
REQ-025 DIV=4, run=1 -> X3 entered at edge 60, sync=1 from edge 60 through edge 67, A1 at edge 68; period 64 cycles; one-hot holds throughout.
REQ-026 run dropped during M1 -> cycle completes to X3; no clk1 issued afterwards; clk2 issued once inside X3 and then none; state holds X3 with sync=1 indefinitely.
REQ-027 From the stopped state, run raised 1 cycle after a wrap -> clk1 and A1 appear at the next wrap (at most 4 cycles later); spacing then matches REQ-024.
REQ-028 poc pulsed for 1 cycle in the middle of X1, between clk1 and clk2 -> outputs clear at once; no clk2 follows; state=X3, sync=1; first clk1 on the 4th edge after release.
REQ-029 DIV=2, run=1 -> clk1/clk2 strobes alternate every 2 cycles, never overlap, and the full cycle period is 32 cycles.
